// File: rtl/pingpong_fifo_sched_pkg.sv
// Shared types and helpers for the ping-pong capture FIFO scheduler.
// Parameter defaults live here so the top and the tracker agree.
package pingpong_fifo_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RST,
    S_SETTLE,
    S_WRITE,
    S_DONE
  } state_e;

  typedef logic bank_t;

  localparam int unsigned INIT_WAIT_DEF    = 7;
  localparam int unsigned RST_LEN_DEF      = 5;
  localparam int unsigned RST_TO_WE_DEF    = 5;
  localparam int unsigned BLOCK_WORDS_DEF  = 4085;
  localparam int unsigned TOTAL_BLOCKS_DEF = 120;
  localparam int unsigned READY_DELAY_DEF  = 5;

  // Block period P: reset + settle + write window.
  function automatic int unsigned period(
    int unsigned rl,
    int unsigned rw,
    int unsigned bw
  );
    return rl + rw + bw;
  endfunction

  function automatic int unsigned max4(
    int unsigned a,
    int unsigned b,
    int unsigned c,
    int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [1:0] bank_oh(bank_t b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pingpong_fifo_sched_if.sv
// Host/FIFO-side signal bundle of the ping-pong scheduler.
// master = capture control side, slave = scheduler.
interface pingpong_fifo_sched_if;
  logic START;
  logic EP_ACK;
  logic FULL_X0;
  logic FULL_X1;
  logic RST_X0;
  logic RST_X1;
  logic WE_X0;
  logic WE_X1;
  logic RD_SEL;
  logic EP_READY;
  logic BUSY;
  logic DONE;
  logic OVERRUN;
  logic ERR_FULL;

  modport master (
    output START, EP_ACK, FULL_X0, FULL_X1,
    input  RST_X0, RST_X1, WE_X0, WE_X1,
    input  RD_SEL, EP_READY, BUSY, DONE,
    input  OVERRUN, ERR_FULL
  );

  modport slave (
    input  START, EP_ACK, FULL_X0, FULL_X1,
    output RST_X0, RST_X1, WE_X0, WE_X1,
    output RD_SEL, EP_READY, BUSY, DONE,
    output OVERRUN, ERR_FULL
  );
endinterface

// File: rtl/pingpong_fifo_sched_ready.sv
// Ready tracker: delays block-end into EP_READY/RD_SEL,
// handles host ACK and the sticky OVERRUN flag.
module pingpong_ready_tracker
  import pingpong_fifo_sched_pkg::*;
#(
  parameter int unsigned READY_DELAY = READY_DELAY_DEF
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  arm_i,
  input  bank_t arm_bank_i,
  input  logic  ack_i,
  input  logic  clr_i,
  output logic  ready_o,
  output bank_t rd_sel_o,
  output logic  overrun_o
);

  localparam int TW = $clog2(READY_DELAY + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(READY_DELAY - 1);

  logic [TW-1:0] tmr_q;
  logic          act_q;
  bank_t         bank_q;
  logic          ready_q;
  bank_t         sel_q;
  logic          ovr_q;
  logic          expire;

  assign expire = act_q && (tmr_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q   <= '0;
      act_q   <= 1'b0;
      bank_q  <= 1'b0;
      ready_q <= 1'b0;
      sel_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Delay < P, so at most one block is ever in flight here.
      if (arm_i) begin
        act_q  <= 1'b1;
        tmr_q  <= TMR_LOAD;
        bank_q <= arm_bank_i;
      end else if (act_q) begin
        if (tmr_q == '0) act_q <= 1'b0;
        else             tmr_q <= tmr_q - TW'(1);
      end
      // Expiry beats a same-edge ACK and then does not count as overrun.
      if (expire) begin
        ready_q <= 1'b1;
        sel_q   <= bank_q;
        if (ready_q && !ack_i) ovr_q <= 1'b1;
      end else if (ack_i && ready_q) begin
        ready_q <= 1'b0;
      end
      if (clr_i) ovr_q <= 1'b0;
    end
  end

  assign ready_o   = ready_q;
  assign rd_sel_o  = sel_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/pingpong_fifo_sched.sv
// Ping-pong capture FIFO write-side scheduler: bank reset,
// settle and write windows, alternating banks per block.
module pingpong_fifo_sched
  import pingpong_fifo_sched_pkg::*;
#(
  parameter int unsigned INIT_WAIT    = INIT_WAIT_DEF,
  parameter int unsigned RST_LEN      = RST_LEN_DEF,
  parameter int unsigned RST_TO_WE    = RST_TO_WE_DEF,
  parameter int unsigned BLOCK_WORDS  = BLOCK_WORDS_DEF,
  parameter int unsigned TOTAL_BLOCKS = TOTAL_BLOCKS_DEF,
  parameter int unsigned READY_DELAY  = READY_DELAY_DEF
) (
  input logic CLK,
  input logic RST_BAR,
  pingpong_fifo_sched_if.slave bus
);

  localparam int unsigned P =
    period(RST_LEN, RST_TO_WE, BLOCK_WORDS);
  localparam int unsigned RD_DLY =
    (READY_DELAY < P) ? READY_DELAY : P - 1;
  localparam int unsigned CMAX =
    max4(INIT_WAIT, RST_LEN, RST_TO_WE, BLOCK_WORDS);
  localparam int CW = $clog2(CMAX + 1);
  localparam int KW = $clog2(TOTAL_BLOCKS + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(RST_TO_WE - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(BLOCK_WORDS - 1);
  localparam logic [KW-1:0] BLK_LAST  = KW'(TOTAL_BLOCKS - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [KW-1:0] blk_q;
  bank_t         bank_q;
  logic [1:0]    rst_q;
  logic [1:0]    we_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic  start_ok;
  logic  blk_end;
  logic  ready;
  bank_t rd_sel;
  logic  ovr;

  assign start_ok = bus.START &&
    (state_q == S_IDLE || state_q == S_DONE);
  assign blk_end = (state_q == S_WRITE) && (cnt_q == WR_LAST);

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      bank_q  <= 1'b0;
      rst_q   <= '0;
      we_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (|(we_q & {bus.FULL_X1, bus.FULL_X0})) err_q <= 1'b1;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            blk_q   <= '0;
            bank_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            rst_q   <= bank_oh(bank_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
            rst_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            state_q <= S_WRITE;
            cnt_q   <= '0;
            we_q    <= bank_oh(bank_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (blk_end) begin
            cnt_q <= '0;
            we_q  <= '0;
            blk_q <= blk_q + KW'(1);
            if (blk_q == BLK_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RST;
              bank_q  <= ~bank_q;
              rst_q   <= bank_oh(~bank_q);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  pingpong_ready_tracker #(
    .READY_DELAY(RD_DLY)
  ) u_ready (
    .clk_i     (CLK),
    .rst_ni    (RST_BAR),
    .arm_i     (blk_end),
    .arm_bank_i(bank_q),
    .ack_i     (bus.EP_ACK),
    .clr_i     (start_ok),
    .ready_o   (ready),
    .rd_sel_o  (rd_sel),
    .overrun_o (ovr)
  );

  assign bus.RST_X0   = rst_q[0];
  assign bus.RST_X1   = rst_q[1];
  assign bus.WE_X0    = we_q[0];
  assign bus.WE_X1    = we_q[1];
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR_FULL = err_q;
  assign bus.EP_READY = ready;
  assign bus.RD_SEL   = rd_sel;
  assign bus.OVERRUN  = ovr;

endmodule
